div_result_deser: RTL and testbench

- Sits directly downstream of the Divider and consumes its 1-bit serial result stream (out_valid/out_data).
- Assembles each contiguous valid burst into a parallel quotient/remainder pair and checks the burst length.
- Holds one result for a valid/ready consumer and flags overruns.
- Gives the PATTERN/scoreboard side and later stages a parallel, handshaked view of divider results.

---
 rtl/div_result_deser.sv | 84 ++++++++
 tb/tb_div_result_deser.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_deser.sv
// rtl/div_result_deser.sv - deserialises divider result bursts into a handshaked quotient/remainder slot
module div_result_deser #(
    parameter int Q_W = 4,
    parameter int R_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ser_valid,
    input  logic           ser_data,
    input  logic           res_ready,
    input  logic           clr_overrun,
    output logic           res_valid,
    output logic [Q_W-1:0] quotient,
    output logic [R_W-1:0] remainder,
    output logic           len_err,
    output logic           overrun
);
    localparam int TOT = Q_W + R_W;
    localparam int CW  = $clog2(TOT + 2);
    localparam logic [CW-1:0] CNT_TOT = CW'(TOT);
    localparam logic [CW-1:0] CNT_SAT = CW'(TOT + 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state;
    logic [TOT-1:0]  shreg;
    logic [CW-1:0]   cnt;
    logic            done;

    // Burst ends on the first low ser_valid sample while collecting.
    assign done = (state == COLLECT) && !ser_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            len_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ser_valid) begin
                        shreg <= {{(TOT-1){1'b0}}, ser_data};
                        cnt   <= CW'(1);
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (ser_valid) begin
                        shreg <= {shreg[TOT-2:0], ser_data};
                        if (cnt != CNT_SAT) begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (clr_overrun) begin
                overrun <= 1'b0;
            end

            // A new overrun overrides a same-cycle clear.
            if (done) begin
                if (!res_valid || res_ready) begin
                    quotient  <= shreg[TOT-1:R_W];
                    remainder <= shreg[R_W-1:0];
                    len_err   <= (cnt != CNT_TOT);
                    res_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_result_deser.sv
// tb/tb_div_result_deser.sv - directed self-checking bench for div_result_deser
module tb_div_result_deser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_valid = 1'b0;
    logic       ser_data = 1'b0;
    logic       res_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       res_valid;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       len_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    logic [3:0] acc_q [0:7];
    logic [3:0] acc_r [0:7];
    int         acc_n = 0;

    div_result_deser #(.Q_W(4), .R_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_data(ser_data),
        .res_ready(res_ready), .clr_overrun(clr_overrun), .res_valid(res_valid),
        .quotient(quotient), .remainder(remainder), .len_err(len_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && res_valid && res_ready && acc_n < 8) begin
            acc_q[acc_n] = quotient;
            acc_r[acc_n] = remainder;
            acc_n = acc_n + 1;
        end
    end

    // Drives n bits MSB-first from bits[n-1:0], then one low ser_valid cycle.
    task automatic send_burst(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            ser_valid = 1'b1;
            ser_data  = bits[i];
        end
        @(negedge clk);
        ser_valid = 1'b0;
        ser_data  = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_res_valid: got %b want 0", res_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({res_valid, quotient, remainder, len_err, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b q=%h r=%h le=%b ov=%b want all 0",
                     res_valid, quotient, remainder, len_err, overrun);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        send_burst(16'b0100_0001, 8);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL normal_early_valid: got %b want 0", res_valid);
        end
        @(negedge clk);
        checks++;
        if ({res_valid, quotient, remainder, len_err} !== {1'b1, 4'h4, 4'h1, 1'b0}) begin
            errors++;
            $display("FAIL normal_result: got v=%b q=%h r=%h le=%b want v=1 q=4 r=1 le=0",
                     res_valid, quotient, remainder, len_err);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, quotient, remainder, len_err} !== {1'b1, 4'h4, 4'h1, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got v=%b q=%h r=%h le=%b want v=1 q=4 r=1 le=0",
                         i, res_valid, quotient, remainder, len_err);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if ({res_valid, quotient, remainder} !== {1'b0, 4'h4, 4'h1}) begin
            errors++;
            $display("FAIL backpressure_drain: got v=%b q=%h r=%h want v=0 q=4 r=1",
                     res_valid, quotient, remainder);
        end
    endtask

    task automatic test_overrun();
        res_ready = 1'b0;
        send_burst(16'b0100_0001, 8);
        send_burst(16'b0011_0011, 8);
        @(negedge clk);
        checks++;
        if ({res_valid, quotient, remainder, overrun} !== {1'b1, 4'h4, 4'h1, 1'b1}) begin
            errors++;
            $display("FAIL overrun_set: got v=%b q=%h r=%h ov=%b want v=1 q=4 r=1 ov=1",
                     res_valid, quotient, remainder, overrun);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        drain();
    endtask

    task automatic test_len_err();
        send_burst(16'b11_0101, 6);
        @(negedge clk);
        checks++;
        if ({res_valid, quotient, remainder, len_err} !== {1'b1, 4'h3, 4'h5, 1'b1}) begin
            errors++;
            $display("FAIL len_short: got v=%b q=%h r=%h le=%b want v=1 q=3 r=5 le=1",
                     res_valid, quotient, remainder, len_err);
        end
        drain();
        send_burst(16'b11_1001_1001, 10);
        @(negedge clk);
        checks++;
        if ({res_valid, quotient, remainder, len_err} !== {1'b1, 4'h9, 4'h9, 1'b1}) begin
            errors++;
            $display("FAIL len_long: got v=%b q=%h r=%h le=%b want v=1 q=9 r=9 le=1",
                     res_valid, quotient, remainder, len_err);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        acc_n = 0;
        res_ready = 1'b1;
        send_burst(16'b0011_0011, 8);
        send_burst(16'b0001_0000, 8);
        repeat (2) @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (acc_n !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", acc_n);
        end else begin
            checks++;
            if ({acc_q[0], acc_r[0], acc_q[1], acc_r[1]} !== 16'h3310) begin
                errors++;
                $display("FAIL b2b_values: got %h/%h %h/%h want 3/3 1/0",
                         acc_q[0], acc_r[0], acc_q[1], acc_r[1]);
            end
        end
        checks++;
        if ({res_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_flags: got v=%b ov=%b want v=0 ov=0", res_valid, overrun);
        end
    endtask

    task automatic test_reset_midburst();
        res_ready = 1'b0;
        send_burst(16'b11_0101, 6);
        send_burst(16'b0100_0001, 8);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            ser_valid = 1'b1;
            ser_data  = i[0];
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, quotient, remainder, len_err, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL midburst_async_reset: got v=%b q=%h r=%h le=%b ov=%b want all 0",
                     res_valid, quotient, remainder, len_err, overrun);
        end
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_burst(16'b0011_0001, 8);
        @(negedge clk);
        checks++;
        if ({res_valid, quotient, remainder, len_err, overrun} !== {1'b1, 4'h3, 4'h1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midburst_recovery: got v=%b q=%h r=%h le=%b ov=%b want v=1 q=3 r=1 le=0 ov=0",
                     res_valid, quotient, remainder, len_err, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_overrun();
        test_len_err();
        test_back_to_back();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
